// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin sharing of one in-order FPU unit among NREQ
// requesters, with a tag FIFO that steers each result back to its issuer.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   req_order      per-requester order, held with operands until accepted
//   req_rs1/rs2    packed operands, requester i at [32i+31:32i]
//   req_accepted   one-hot, requester's order taken this cycle
//   req_done       one-hot, requester's result valid on rd this cycle
//   rd             result, straight from u_rd
//   u_order        order to the shared unit
//   u_rs1/u_rs2    granted requester's operands
//   u_accepted     unit took the order
//   u_done, u_rd   unit result valid / result
//   inflight       tag FIFO occupancy
//   err_orphan     sticky: u_done seen with no outstanding tag
module fpu_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_order,
    input  logic [32*NREQ-1:0]       req_rs1,
    input  logic [32*NREQ-1:0]       req_rs2,
    output logic [NREQ-1:0]          req_accepted,
    output logic [NREQ-1:0]          req_done,
    output logic [31:0]              rd,
    output logic                     u_order,
    output logic [31:0]              u_rs1,
    output logic [31:0]              u_rs2,
    input  logic                     u_accepted,
    input  logic                     u_done,
    input  logic [31:0]              u_rd,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_orphan
);

    localparam int AW = $clog2(DEPTH);

    logic [IDW-1:0] r_rr_ptr;
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [IDW-1:0] r_tags [DEPTH];
    logic           r_err;

    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_next_rr;
    logic [IDW-1:0] w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_take;
    logic           w_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing
    // wrap bits means full, fully equal means empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head  = r_tags[r_rd_ptr[AW-1:0]];

    // Scan from r_rr_ptr upward, wrapping at NREQ; first requester wins.
    always_comb begin
        int             v_idx;
        logic [IDW-1:0] v_cand;
        logic           v_found;
        w_grant = r_rr_ptr;
        v_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            v_cand = IDW'(v_idx);
            if (!v_found && req_order[v_cand]) begin
                v_found = 1'b1;
                w_grant = v_cand;
            end
        end
    end

    assign w_next_rr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    // Full is judged on registered occupancy only, so a pop in the same
    // cycle frees the slot for the next cycle, not this one.
    assign u_order = (|req_order) & ~w_full & rstn;
    assign w_take  = u_order & u_accepted;
    assign w_pop   = u_done & ~w_empty;

    always_comb begin
        u_rs1        = '0;
        u_rs2        = '0;
        req_accepted = '0;
        req_done     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                u_rs1           = req_rs1[32*i +: 32];
                u_rs2           = req_rs2[32*i +: 32];
                req_accepted[i] = w_take;
            end
            if (w_head == IDW'(i)) begin
                req_done[i] = w_pop & rstn;
            end
        end
    end

    assign rd         = u_rd;
    assign inflight   = r_wr_ptr - r_rd_ptr;
    assign err_orphan = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            if (w_take) begin
                r_tags[r_wr_ptr[AW-1:0]] <= w_grant;
                r_wr_ptr                 <= r_wr_ptr + 1'b1;
                r_rr_ptr                 <= w_next_rr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (u_done && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Directed bench for fpu_rr_arbiter: the bench itself plays the shared unit.
// Inputs change 1ns after posedge; outputs are sampled before the next edge.
module tb_fpu_rr_arbiter;

    logic         clk;
    logic         rstn;
    logic [3:0]   req_order;
    logic [127:0] req_rs1;
    logic [127:0] req_rs2;
    logic [3:0]   req_accepted;
    logic [3:0]   req_done;
    logic [31:0]  rd;
    logic         u_order;
    logic [31:0]  u_rs1;
    logic [31:0]  u_rs2;
    logic         u_accepted;
    logic         u_done;
    logic [31:0]  u_rd;
    logic [2:0]   inflight;
    logic         err_orphan;

    int n_pass;
    int n_total;

    fpu_rr_arbiter #(.NREQ(4), .IDW(2), .DEPTH(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_order    (req_order),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_accepted (req_accepted),
        .req_done     (req_done),
        .rd           (rd),
        .u_order      (u_order),
        .u_rs1        (u_rs1),
        .u_rs2        (u_rs2),
        .u_accepted   (u_accepted),
        .u_done       (u_done),
        .u_rd         (u_rd),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands();
        for (int i = 0; i < 4; i++) begin
            req_rs1[32*i +: 32] = 32'h1000_0000 + i;
            req_rs2[32*i +: 32] = 32'h2000_0000 + i;
        end
    endtask

    task automatic do_reset();
        req_order  = '0;
        u_accepted = 1'b0;
        u_done     = 1'b0;
        u_rd       = '0;
        rstn       = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        set_operands();
        req_order  = 4'b1111;
        u_accepted = 1'b1;
        u_done     = 1'b1;
        u_rd       = 32'hDEAD_BEEF;
        tick();
        n_total++;
        if (u_order !== 1'b0)
            $display("FAIL rst_u_order got %b want 0", u_order);
        else n_pass++;
        n_total++;
        if (req_accepted !== 4'b0000)
            $display("FAIL rst_acc got %b want 0000", req_accepted);
        else n_pass++;
        n_total++;
        if (req_done !== 4'b0000)
            $display("FAIL rst_done got %b want 0000", req_done);
        else n_pass++;
        n_total++;
        if (inflight !== 3'd0)
            $display("FAIL rst_inflight got %0d want 0", inflight);
        else n_pass++;
        n_total++;
        if (err_orphan !== 1'b0)
            $display("FAIL rst_err got %b want 0", err_orphan);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_rs1[64 +: 32] = 32'h3F80_0000;
        req_rs2[64 +: 32] = 32'h4000_0000;
        req_order  = 4'b0100;
        u_accepted = 1'b1;
        #1;
        n_total++;
        if (u_order !== 1'b1)
            $display("FAIL single_u_order got %b want 1", u_order);
        else n_pass++;
        n_total++;
        if (req_accepted !== 4'b0100)
            $display("FAIL single_acc got %b want 0100", req_accepted);
        else n_pass++;
        n_total++;
        if (u_rs1 !== 32'h3F80_0000 || u_rs2 !== 32'h4000_0000)
            $display("FAIL single_ops got %h/%h want 3f800000/40000000",
                     u_rs1, u_rs2);
        else n_pass++;
        tick();
        n_total++;
        if (inflight !== 3'd1)
            $display("FAIL single_inflight1 got %0d want 1", inflight);
        else n_pass++;
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b1;
        u_rd       = 32'h4040_0000;
        #1;
        n_total++;
        if (req_done !== 4'b0100 || rd !== 32'h4040_0000)
            $display("FAIL single_done got %b/%h want 0100/40400000",
                     req_done, rd);
        else n_pass++;
        tick();
        u_done = 1'b0;
        n_total++;
        if (inflight !== 3'd0)
            $display("FAIL single_inflight0 got %0d want 0", inflight);
        else n_pass++;
        set_operands();
    endtask

    task automatic test_round_robin();
        logic [1:0] g [7];
        logic [3:0] exp_acc;
        logic [3:0] exp_done;
        g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0};
        do_reset();
        u_accepted = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_order = (k < 5) ? 4'b1111 : 4'b1001;
            u_done    = (k > 0);
            #1;
            exp_acc  = 4'b0001 << g[k];
            exp_done = (k > 0) ? (4'b0001 << g[k-1]) : 4'b0000;
            n_total++;
            if (req_accepted !== exp_acc)
                $display("FAIL rr_acc[%0d] got %b want %b",
                         k, req_accepted, exp_acc);
            else n_pass++;
            n_total++;
            if (req_done !== exp_done)
                $display("FAIL rr_done[%0d] got %b want %b",
                         k, req_done, exp_done);
            else n_pass++;
            tick();
        end
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b1;
        #1;
        n_total++;
        if (req_done !== 4'b0001)
            $display("FAIL rr_drain got %b want 0001", req_done);
        else n_pass++;
        tick();
        u_done = 1'b0;
        n_total++;
        if (inflight !== 3'd0)
            $display("FAIL rr_inflight got %0d want 0", inflight);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [1:0] d [4];
        logic [3:0] exp_done;
        d = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_order  = 4'b1111;
        u_accepted = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_total++;
        if (inflight !== 3'd4)
            $display("FAIL full_inflight got %0d want 4", inflight);
        else n_pass++;
        n_total++;
        if (u_order !== 1'b0 || req_accepted !== 4'b0000)
            $display("FAIL full_block got %b/%b want 0/0000",
                     u_order, req_accepted);
        else n_pass++;
        u_done = 1'b1;
        #1;
        n_total++;
        if (req_done !== 4'b0001 || u_order !== 1'b0)
            $display("FAIL full_pop got %b/%b want 0001/0",
                     req_done, u_order);
        else n_pass++;
        tick();
        u_done = 1'b0;
        #1;
        n_total++;
        if (inflight !== 3'd3 || u_order !== 1'b1 || req_accepted !== 4'b0001)
            $display("FAIL full_reopen got %0d/%b/%b want 3/1/0001",
                     inflight, u_order, req_accepted);
        else n_pass++;
        tick();
        n_total++;
        if (inflight !== 3'd4)
            $display("FAIL full_refill got %0d want 4", inflight);
        else n_pass++;
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_done = 4'b0001 << d[k];
            n_total++;
            if (req_done !== exp_done)
                $display("FAIL full_drain[%0d] got %b want %b",
                         k, req_done, exp_done);
            else n_pass++;
            tick();
        end
        u_done = 1'b0;
        n_total++;
        if (inflight !== 3'd0)
            $display("FAIL full_empty got %0d want 0", inflight);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ord [12];
        logic [1:0] g [12];
        logic [3:0] exp_acc;
        logic [3:0] exp_done;
        ord = '{4'b0110, 4'b0011, 4'b1100, 4'b0101, 4'b1000, 4'b1010,
                4'b1010, 4'b0001, 4'b0001, 4'b1101, 4'b0110, 4'b0100};
        g   = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1,
                2'd3, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2};
        do_reset();
        u_accepted = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_order = ord[k];
            u_done    = (k >= 2);
            #1;
            exp_acc  = 4'b0001 << g[k];
            exp_done = (k >= 2) ? (4'b0001 << g[k-2]) : 4'b0000;
            n_total++;
            if (req_accepted !== exp_acc)
                $display("FAIL b2b_acc[%0d] got %b want %b",
                         k, req_accepted, exp_acc);
            else n_pass++;
            n_total++;
            if (u_rs1 !== 32'h1000_0000 + g[k] ||
                u_rs2 !== 32'h2000_0000 + g[k])
                $display("FAIL b2b_ops[%0d] got %h/%h want req %0d",
                         k, u_rs1, u_rs2, g[k]);
            else n_pass++;
            n_total++;
            if (req_done !== exp_done)
                $display("FAIL b2b_done[%0d] got %b want %b",
                         k, req_done, exp_done);
            else n_pass++;
            tick();
            if (k >= 1) begin
                n_total++;
                if (inflight !== 3'd2)
                    $display("FAIL b2b_inflight[%0d] got %0d want 2",
                             k, inflight);
                else n_pass++;
            end
        end
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b1;
        for (int k = 10; k < 12; k++) begin
            #1;
            exp_done = 4'b0001 << g[k];
            n_total++;
            if (req_done !== exp_done)
                $display("FAIL b2b_drain[%0d] got %b want %b",
                         k, req_done, exp_done);
            else n_pass++;
            tick();
        end
        u_done = 1'b0;
        n_total++;
        if (inflight !== 3'd0 || err_orphan !== 1'b0)
            $display("FAIL b2b_end got %0d/%b want 0/0",
                     inflight, err_orphan);
        else n_pass++;
    endtask

    task automatic test_orphan();
        do_reset();
        u_done = 1'b1;
        u_rd   = 32'h1234_5678;
        #1;
        n_total++;
        if (req_done !== 4'b0000 || err_orphan !== 1'b0)
            $display("FAIL orphan_pre got %b/%b want 0000/0",
                     req_done, err_orphan);
        else n_pass++;
        tick();
        u_done = 1'b0;
        n_total++;
        if (err_orphan !== 1'b1)
            $display("FAIL orphan_set got %b want 1", err_orphan);
        else n_pass++;
        for (int k = 0; k < 3; k++) tick();
        n_total++;
        if (err_orphan !== 1'b1)
            $display("FAIL orphan_sticky got %b want 1", err_orphan);
        else n_pass++;
        do_reset();
        n_total++;
        if (err_orphan !== 1'b0)
            $display("FAIL orphan_clear got %b want 0", err_orphan);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_order  = 4'b1111;
        u_accepted = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        u_done = 1'b1;
        #1;
        n_total++;
        if (inflight !== 3'd3 || u_order !== 1'b1 || req_done !== 4'b0001)
            $display("FAIL arst_pre got %0d/%b/%b want 3/1/0001",
                     inflight, u_order, req_done);
        else n_pass++;
        #1 rstn = 1'b0;
        #1;
        n_total++;
        if (u_order !== 1'b0 || req_accepted !== 4'b0000 ||
            req_done !== 4'b0000)
            $display("FAIL arst_comb got %b/%b/%b want 0/0000/0000",
                     u_order, req_accepted, req_done);
        else n_pass++;
        n_total++;
        if (inflight !== 3'd0 || err_orphan !== 1'b0)
            $display("FAIL arst_regs got %0d/%b want 0/0",
                     inflight, err_orphan);
        else n_pass++;
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b0;
        #1 rstn = 1'b1;
        #1;
        req_order  = 4'b1001;
        u_accepted = 1'b1;
        #1;
        n_total++;
        if (req_accepted !== 4'b0001)
            $display("FAIL arst_rrptr got %b want 0001", req_accepted);
        else n_pass++;
        req_order  = 4'b0000;
        u_accepted = 1'b0;
        u_done     = 1'b1;
        tick();
        n_total++;
        if (err_orphan !== 1'b1 || req_done !== 4'b0000)
            $display("FAIL arst_orphan got %b/%b want 1/0000",
                     err_orphan, req_done);
        else n_pass++;
        u_done = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_back_to_back();
        test_orphan();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_rr_arbiter.md
Name: fpu_rr_arbiter

Overview:
- Shares one FPU arithmetic unit (fadd-style order/accepted/done handshake, results in issue order) between NREQ requesters.
- Grants in round-robin order and muxes the granted requester's operands to the unit.
- Records the requester index of every accepted operation in a tag FIFO and routes each done back to the requester that issued it.
- Sits between the core's FP issue ports and a single shared unit instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester index width; must equal clog2(NREQ).
- DEPTH, 4, tag FIFO entries; maximum operations in flight (power of two, ≥2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_order  in  NREQ  per-requester order; held with operands until accepted
- req_rs1  in  32*NREQ  packed operand 1; requester i is at [32i+31:32i]
- req_rs2  in  32*NREQ  packed operand 2
- req_accepted  out  NREQ  one-hot; requester i's order taken this cycle
- req_done  out  NREQ  one-hot; requester i's result valid on rd this cycle
- rd  out  32  result, driven straight from u_rd
- u_order  out  1  order to the shared unit
- u_rs1  out  32  granted operand 1
- u_rs2  out  32  granted operand 2
- u_accepted  in  1  unit took the order
- u_done  in  1  unit result valid
- u_rd  in  32  unit result
- inflight  out  clog2(DEPTH)+1  tag FIFO occupancy
- err_orphan  out  1  sticky: u_done arrived with the tag FIFO empty

Behaviour:
- Reset (async, rstn=0):
  - rr_ptr=0, FIFO rd/wr pointers=0, inflight=0, err_orphan=0.
  - All combinational outputs are forced to 0 while rstn=0: u_order, req_accepted, req_done.
  - Reset mid-operation discards all tags. Results the unit returns later are orphans: err_orphan is set and no req_done is raised.
- Grant (combinational):
  - g = first i with req_order[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - u_order = (|req_order) & (inflight != DEPTH) & rstn.
  - u_rs1/u_rs2 = operands of requester g. When no request is pending they select requester rr_ptr; their value is don't-care.
- Accept:
  - req_accepted[g] = u_order & u_accepted; all other bits are 0.
  - Combinational pass-through, no added latency.
- On each clk edge with acceptance:
  - push g into the FIFO;
  - rr_ptr <= (g+1) mod NREQ.
  - With no acceptance, rr_ptr holds, even if requests are pending.
- Completion:
  - When u_done=1 and FIFO non-empty: req_done[head]=1 in the same cycle, rd=u_rd, and head is popped at the edge.
  - When u_done=1 and FIFO empty: req_done=0, and err_orphan <= 1 (sticky until reset).
- Simultaneous push and pop: both happen; inflight is unchanged.
- Full: with inflight=DEPTH, u_order=0 and requests wait. A pop in the same cycle does not re-enable u_order until the next cycle (no full bypass).
- Pointer wrap: FIFO pointers are clog2(DEPTH)+1 bits; full/empty is decided by MSB comparison.
- Latency added by the arbiter: 0 cycles on both accept and done paths.
  - With a 2-cycle fadd-style unit (accept at T, done at T+1), requester i sees req_accepted at T and req_done at T+1.
- Ordering and fairness:
  - The unit must complete in issue order; the arbiter never reorders tags.
  - A continuously requesting port is granted within NREQ acceptances.
- A requester dropping req_order before acceptance is legal and simply removes it from arbitration.

Test Plan:
- Single op: req_order=4'b0100, rs1=0x3F800000, rs2=0x40000000, unit accepts at T, done at T+1 with u_rd=0x40400000 -> req_accepted=4'b0100 at T, req_done=4'b0100 with rd=0x40400000 at T+1, inflight 1→0.
- Round robin: req_order=4'b1111 held, unit accepting every cycle -> grant order 0,1,2,3,0. Then only 4'b1001 pending with rr_ptr=1 -> grant 3 then 0.
- Full: unit accepts 4 orders and withholds done -> inflight=4, u_order=0 even though req_order≠0. First u_done -> req_done goes to the first issuer; u_order rises the following cycle.
- Simultaneous: push and pop in the same cycle at inflight=2 -> inflight stays 2; the tag sequence across FIFO wrap (≥9 ops, DEPTH=4) matches issue order exactly.
- Orphan: u_done=1 with inflight=0 -> req_done=0, err_orphan=1 and remains 1 until rstn=0.
- Async reset: drop rstn mid-cycle with inflight=3 -> outputs go 0 immediately, no clock required. After release, inflight=0 and rr_ptr=0; a later u_done sets err_orphan.
